// File: rtl/message_arbiter_if.sv
// Bus between the requesters / print engine and the message arbiter.
// master: requesters and engine (drive requests and Busy).
// slave:  the arbiter (drives grants, latched command fields and status).
interface message_arbiter_if #(
  parameter int NREQ   = 4,
  parameter int BW_MSG = 6,
  parameter int BW_X   = 7,
  parameter int BW_Y   = 5
);
  logic                   Enable;
  logic [NREQ-1:0]        Req;
  logic [NREQ*BW_MSG-1:0] ReqMsg;
  logic [NREQ-1:0]        ReqColor;
  logic [NREQ-1:0]        ReqChar;
  logic [NREQ*BW_X-1:0]   ReqX;
  logic [NREQ*BW_Y-1:0]   ReqY;
  logic [NREQ-1:0]        Ack;
  logic                   Start;
  logic [BW_MSG-1:0]      MessageNumber;
  logic                   Color;
  logic                   Char;
  logic [BW_X-1:0]        PosX;
  logic [BW_Y-1:0]        PosY;
  logic                   Busy;
  logic                   Active;
  logic [2:0]             Owner;
  logic                   Error;
  logic                   ClearError;

  modport master (
    output Enable, Req, ReqMsg, ReqColor, ReqChar, ReqX, ReqY, Busy, ClearError,
    input  Ack, Start, MessageNumber, Color, Char, PosX, PosY, Active, Owner, Error
  );

  modport slave (
    input  Enable, Req, ReqMsg, ReqColor, ReqChar, ReqX, ReqY, Busy, ClearError,
    output Ack, Start, MessageNumber, Color, Char, PosX, PosY, Active, Owner, Error
  );
endinterface

// File: rtl/message_arbiter.sv
// Round-robin arbiter sharing one message ROM / font-writer engine between
// NREQ requesters. One job at a time: latch command, pulse Start, wait for
// Busy to rise and fall, one gap cycle, then the next grant. A watchdog
// drops jobs whose engine never starts or never finishes.
module message_arbiter #(
  parameter int NREQ    = 4,
  parameter int BW_MSG  = 6,
  parameter int BW_X    = 7,
  parameter int BW_Y    = 5,
  parameter int TIMEOUT = 4096,
  parameter int BW_TO   = 12
) (
  input  logic Clock,
  input  logic Reset,
  message_arbiter_if.slave bus
);
  localparam int BW_IDX = $clog2(NREQ);

  typedef enum logic [2:0] {IDLE, ISSUE, WAIT_BUSY, WAIT_DONE, GAP} state_t;

  state_t            state, stateNext;
  logic [2:0]        ptr, offset, pick, pickNext;
  logic [3:0]        pickSum;
  logic [2*NREQ-1:0] reqTwice;
  logic [NREQ-1:0]   reqRot;
  logic              anyReq, grant, toLast, toExpire;
  logic [BW_TO-1:0]  toCnt;

  // Rotate Req so that bit 0 is the requester the pointer currently favours.
  assign reqTwice = {bus.Req, bus.Req};
  assign reqRot   = NREQ'(reqTwice >> ptr);
  assign anyReq   = |reqRot;

  // Lowest set bit of the rotated vector is the first requester at or after ptr.
  always_comb begin
    // NOTE: every variable assigned here gets a default first, so no path
    // leaves it unassigned and no latch is inferred.
    offset = '0;
    for (int i = NREQ - 1; i >= 0; i--)
      if (reqRot[BW_IDX'(i)]) offset = 3'(i);
  end

  assign pickSum  = {1'b0, ptr} + {1'b0, offset};
  assign pick     = (pickSum >= 4'(NREQ)) ? 3'(pickSum - 4'(NREQ)) : pickSum[2:0];
  assign pickNext = (pick == 3'(NREQ - 1)) ? 3'd0 : pick + 3'd1;

  // Counter is about to reach TIMEOUT-1 while the wait is still unmet.
  assign toLast = (toCnt == BW_TO'(TIMEOUT - 2));

  // State register.
  always_ff @(posedge Clock or posedge Reset) begin
    // NOTE: sequential state uses non-blocking assignments so every flop
    // samples pre-edge values regardless of block ordering.
    if (Reset) state <= IDLE;
    else       state <= stateNext;
  end

  // Next-state logic, grant decision and watchdog abort.
  always_comb begin
    stateNext = state;
    grant     = 1'b0;
    toExpire  = 1'b0;
    case (state)
      IDLE: begin
        if (bus.Enable && anyReq) begin
          stateNext = ISSUE;
          grant     = 1'b1;
        end
      end
      ISSUE: stateNext = WAIT_BUSY;
      WAIT_BUSY: begin
        if (bus.Busy) stateNext = WAIT_DONE;
        else if (toLast) begin
          stateNext = IDLE;
          toExpire  = 1'b1;
        end
      end
      WAIT_DONE: begin
        if (!bus.Busy) stateNext = GAP;
        else if (toLast) begin
          stateNext = IDLE;
          toExpire  = 1'b1;
        end
      end
      GAP:     stateNext = IDLE;
      default: stateNext = IDLE;
    endcase
  end

  // Registered outputs, command latch, round-robin pointer, watchdog, Error.
  always_ff @(posedge Clock or posedge Reset) begin
    if (Reset) begin
      bus.Start         <= 1'b0;
      bus.Ack           <= '0;
      bus.Active        <= 1'b0;
      bus.Owner         <= '0;
      bus.MessageNumber <= '0;
      bus.Color         <= 1'b0;
      bus.Char          <= 1'b0;
      bus.PosX          <= '0;
      bus.PosY          <= '0;
      bus.Error         <= 1'b0;
      ptr               <= '0;
      toCnt             <= '0;
    end else begin
      bus.Start  <= (stateNext == ISSUE);
      bus.Active <= (stateNext != IDLE);
      bus.Ack    <= grant ? ({{(NREQ-1){1'b0}}, 1'b1} << pick) : '0;

      if (grant) begin
        bus.MessageNumber <= BW_MSG'(bus.ReqMsg >> (32'(pick) * BW_MSG));
        bus.Color         <= 1'(bus.ReqColor >> pick);
        bus.Char          <= 1'(bus.ReqChar >> pick);
        bus.PosX          <= BW_X'(bus.ReqX >> (32'(pick) * BW_X));
        bus.PosY          <= BW_Y'(bus.ReqY >> (32'(pick) * BW_Y));
        bus.Owner         <= pick;
        ptr               <= pickNext;
      end

      if (state == ISSUE)
        toCnt <= '0;
      else if (state == WAIT_BUSY || state == WAIT_DONE)
        toCnt <= toCnt + BW_TO'(1);

      // A timeout in the same cycle as ClearError leaves the flag set.
      if (toExpire)            bus.Error <= 1'b1;
      else if (bus.ClearError) bus.Error <= 1'b0;
    end
  end
endmodule

// File: tb/tb_message_arbiter.sv
// Directed bench for message_arbiter: single job, round robin, late request,
// watchdog and Error handling, Enable gating, reset mid-job.
module tb_message_arbiter;
  localparam int NREQ    = 4;
  localparam int BW_MSG  = 6;
  localparam int BW_X    = 7;
  localparam int BW_Y    = 5;
  localparam int TIMEOUT = 16;
  localparam int BW_TO   = 4;

  logic Clock = 1'b0;
  logic Reset = 1'b1;

  message_arbiter_if #(.NREQ(NREQ), .BW_MSG(BW_MSG), .BW_X(BW_X), .BW_Y(BW_Y)) bus ();

  message_arbiter #(
    .NREQ(NREQ), .BW_MSG(BW_MSG), .BW_X(BW_X), .BW_Y(BW_Y),
    .TIMEOUT(TIMEOUT), .BW_TO(BW_TO)
  ) dut (
    .Clock(Clock),
    .Reset(Reset),
    .bus(bus)
  );

  always #5 Clock = ~Clock;

  int cyc = 0;
  always @(posedge Clock) cyc <= cyc + 1;

  // Engine model: a job lasts engLen cycles counted from the Start cycle;
  // Busy is high for cycles 1..engLen-1 after Start and low again at engLen.
  int engLen  = 5;
  bit engDead = 1'b0;
  int engCnt;
  always @(posedge Clock or posedge Reset) begin
    if (Reset) begin
      engCnt   <= 0;
      bus.Busy <= 1'b0;
    end else if (bus.Start && !engDead) begin
      engCnt   <= engLen - 2;
      bus.Busy <= 1'b1;
    end else if (engCnt != 0) begin
      engCnt <= engCnt - 1;
    end else begin
      bus.Busy <= 1'b0;
    end
  end

  int nVectors = 0;
  int nMiss    = 0;

  task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
    nVectors++;
    if (got !== exp) begin
      nMiss++;
      $display("FAIL %s: observed %0d, expected %0d", tag, got, exp);
    end
  endtask

  task automatic setFields(input int i, input int msg, input bit color, input bit chr,
                           input int x, input int y);
    bus.ReqMsg[i*BW_MSG +: BW_MSG] = BW_MSG'(msg);
    bus.ReqColor[i]                = color;
    bus.ReqChar[i]                 = chr;
    bus.ReqX[i*BW_X +: BW_X]       = BW_X'(x);
    bus.ReqY[i*BW_Y +: BW_Y]       = BW_Y'(y);
  endtask

  task automatic waitStart(input int budget, output bit ok);
    ok = 1'b0;
    for (int k = 0; k < budget && !ok; k++) begin
      @(negedge Clock);
      if (bus.Start === 1'b1) ok = 1'b1;
    end
  endtask

  task automatic waitIdle(input string tag, input int budget);
    bit ok;
    ok = 1'b0;
    for (int k = 0; k < budget && !ok; k++) begin
      @(negedge Clock);
      if (bus.Active === 1'b0) ok = 1'b1;
    end
    check(tag, 32'(ok), 1);
  endtask

  // Cycle where Busy first goes low after being high, and where Active goes low.
  task automatic runTail(input int budget, output int busyFell, output int activeFell);
    bit sawBusy;
    sawBusy    = 1'b0;
    busyFell   = -100;
    activeFell = -1;
    for (int k = 0; k < budget && activeFell < 0; k++) begin
      if (sawBusy && bus.Busy === 1'b0 && busyFell < 0) busyFell = cyc;
      if (bus.Busy === 1'b1) sawBusy = 1'b1;
      if (bus.Active === 1'b0) activeFell = cyc;
      else @(negedge Clock);
    end
  endtask

  task automatic resetPulse();
    @(negedge Clock);
    Reset = 1'b1;
    @(negedge Clock);
    Reset = 1'b0;
  endtask

  initial begin
    #100000;
    $display("FAIL global_timeout: observed hang, expected finish");
    $fatal(1);
  end

  initial begin
    bit ok;
    int s, bf, af, starts;
    int startCyc[6];

    bus.Enable     = 1'b0;
    bus.Req        = '0;
    bus.ReqMsg     = '0;
    bus.ReqColor   = '0;
    bus.ReqChar    = '0;
    bus.ReqX       = '0;
    bus.ReqY       = '0;
    bus.ClearError = 1'b0;

    // Reset state.
    @(negedge Clock);
    @(negedge Clock);
    check("rst_start",  32'(bus.Start), 0);
    check("rst_ack",    32'(bus.Ack), 0);
    check("rst_active", 32'(bus.Active), 0);
    check("rst_owner",  32'(bus.Owner), 0);
    check("rst_error",  32'(bus.Error), 0);
    check("rst_msg",    32'(bus.MessageNumber), 0);
    Reset = 1'b0;

    // Single job: one-cycle grant latency, fields held, Active tail.
    setFields(0, 12, 1'b1, 1'b0, 20, 3);
    engLen     = 10;
    bus.Enable = 1'b1;
    @(negedge Clock);
    bus.Req = 4'b0001;
    @(negedge Clock);
    check("t1_start_latency", 32'(bus.Start), 1);
    check("t1_ack",           32'(bus.Ack), 32'b0001);
    check("t1_msg",           32'(bus.MessageNumber), 12);
    check("t1_color",         32'(bus.Color), 1);
    check("t1_posx",          32'(bus.PosX), 20);
    check("t1_posy",          32'(bus.PosY), 3);
    check("t1_owner",         32'(bus.Owner), 0);
    bus.Req = '0;
    setFields(0, 33, 1'b0, 1'b1, 99, 17);
    @(negedge Clock);
    check("t1_start_width", 32'(bus.Start), 0);
    check("t1_ack_width",   32'(bus.Ack), 0);
    runTail(40, bf, af);
    check("t1_active_after_busy", 32'(af - bf), 2);
    check("t1_msg_held",  32'(bus.MessageNumber), 12);
    check("t1_color_held", 32'(bus.Color), 1);
    check("t1_char_held", 32'(bus.Char), 0);
    check("t1_posx_held", 32'(bus.PosX), 20);
    check("t1_posy_held", 32'(bus.PosY), 3);

    // Round robin with all requests held, 5-cycle engine.
    resetPulse();
    for (int i = 0; i < NREQ; i++) setFields(i, 40 + i, i[0], 1'b0, 10 * i, i);
    engLen  = 5;
    bus.Req = 4'b1111;
    for (int j = 0; j < 6; j++) begin
      waitStart(20, ok);
      check("t2_start_seen", 32'(ok), 1);
      startCyc[j] = cyc;
      if (ok) begin
        check("t2_ack_order", 32'(bus.Ack), 32'(1 << (j % 4)));
        check("t2_owner",     32'(bus.Owner), 32'(j % 4));
        check("t2_msg",       32'(bus.MessageNumber), 32'(40 + j % 4));
      end
    end
    bus.Req = '0;
    for (int j = 1; j < 6; j++)
      check("t2_start_spacing", 32'(startCyc[j] - startCyc[j-1]), 8);
    waitIdle("t2_idle", 30);

    // Late request for requester 2 while job 0 is in WAIT_DONE.
    engLen  = 8;
    bus.Req = 4'b0001;
    waitStart(5, ok);
    check("t3_first_start", 32'(ok), 1);
    check("t3_first_owner", 32'(bus.Owner), 0);
    s       = cyc;
    bus.Req = '0;
    @(negedge Clock);
    @(negedge Clock);
    bus.Req = 4'b0100;
    waitStart(30, ok);
    check("t3_second_start", 32'(ok), 1);
    check("t3_start_cycle",  32'(cyc - s), 11);
    check("t3_owner",        32'(bus.Owner), 2);
    check("t3_ack",          32'(bus.Ack), 32'b0100);
    bus.Req = '0;
    waitIdle("t3_idle", 30);

    // Watchdog: engine never raises Busy.
    engDead = 1'b1;
    bus.Req = 4'b0010;
    waitStart(5, ok);
    check("t4_start", 32'(ok), 1);
    check("t4_owner", 32'(bus.Owner), 1);
    bus.Req = '0;
    repeat (TIMEOUT - 1) @(negedge Clock);
    check("t4_error_early",  32'(bus.Error), 0);
    check("t4_active_early", 32'(bus.Active), 1);
    @(negedge Clock);
    check("t4_error_set",   32'(bus.Error), 1);
    check("t4_active_drop", 32'(bus.Active), 0);
    @(negedge Clock);
    check("t4_error_sticky", 32'(bus.Error), 1);
    bus.ClearError = 1'b1;
    @(negedge Clock);
    bus.ClearError = 1'b0;
    check("t4_error_cleared", 32'(bus.Error), 0);
    bus.Req = 4'b0001;
    waitStart(5, ok);
    check("t4_regrant",       32'(ok), 1);
    check("t4_regrant_owner", 32'(bus.Owner), 0);
    bus.Req = '0;
    repeat (TIMEOUT - 1) @(negedge Clock);
    check("t4_error_before_race", 32'(bus.Error), 0);
    bus.ClearError = 1'b1;
    @(negedge Clock);
    bus.ClearError = 1'b0;
    check("t4_set_beats_clear", 32'(bus.Error), 1);
    bus.ClearError = 1'b1;
    @(negedge Clock);
    bus.ClearError = 1'b0;
    engDead = 1'b0;

    // Enable gating, and Enable dropped mid-job.
    engLen     = 6;
    bus.Enable = 1'b0;
    bus.Req    = 4'b0010;
    starts     = 0;
    for (int k = 0; k < 50; k++) begin
      @(negedge Clock);
      if (bus.Start === 1'b1) starts++;
    end
    check("t5_no_start_disabled", 32'(starts), 0);
    bus.Enable = 1'b1;
    @(negedge Clock);
    check("t5_start_after_enable", 32'(bus.Start), 1);
    check("t5_owner",              32'(bus.Owner), 1);
    bus.Req = '0;
    @(negedge Clock);
    @(negedge Clock);
    bus.Enable = 1'b0;
    runTail(30, bf, af);
    check("t5_job_completes", 32'(af - bf), 2);
    check("t5_no_error",      32'(bus.Error), 0);
    bus.Enable = 1'b1;

    // Reset during WAIT_DONE; pointer restarts at 0.
    engLen  = 8;
    bus.Req = 4'b0100;
    waitStart(5, ok);
    check("t6_start", 32'(ok), 1);
    check("t6_owner", 32'(bus.Owner), 2);
    @(negedge Clock);
    bus.Req = 4'b1100;
    @(negedge Clock);
    Reset = 1'b1;
    #1;
    check("t6_rst_active", 32'(bus.Active), 0);
    check("t6_rst_owner",  32'(bus.Owner), 0);
    check("t6_rst_msg",    32'(bus.MessageNumber), 0);
    check("t6_rst_posx",   32'(bus.PosX), 0);
    check("t6_rst_start",  32'(bus.Start), 0);
    @(negedge Clock);
    Reset = 1'b0;
    waitStart(3, ok);
    check("t6_post_start", 32'(ok), 1);
    check("t6_post_owner", 32'(bus.Owner), 2);
    check("t6_post_ack",   32'(bus.Ack), 32'b0100);
    bus.Req = '0;
    waitIdle("t6_idle", 30);

    $display("== %0d vectors applied, %0d miscompares ==", nVectors, nMiss);
    $finish;
  end
endmodule
